// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: memory port between the multi-cycle MIPS32 core and the
// unified instruction/data memory responder.
//   master : the core (drives MemRead, MemWrite, address, wr_data)
//   slave  : the memory (drives rd_data, ready, err, busy)
interface mips_mem_responder_if;
    logic        MemRead;   // read request level
    logic        MemWrite;  // write request level
    logic [31:0] address;   // byte address
    logic [31:0] wr_data;   // write data (core data_out)
    logic [31:0] rd_data;   // read data (core data_in)
    logic        ready;     // one-cycle response pulse
    logic        err;       // response error, valid only while ready=1
    logic        busy;      // memory FSM not idle

    modport master (
        output MemRead, MemWrite, address, wr_data,
        input  rd_data, ready, err, busy
    );

    modport slave (
        input  MemRead, MemWrite, address, wr_data,
        output rd_data, ready, err, busy
    );
endinterface

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word-wide unified memory answering the MIPS32 core's memory port.
// One request is accepted at a time from idle. Writes commit at the acceptance edge and
// respond on the next cycle; reads respond READ_LAT edges after acceptance. Every response
// is a one-cycle ready pulse with err flagging illegal accesses.
//
// Ports:
//   clk  - rising-edge clock
//   nrst - asynchronous active-low reset (array contents are not cleared)
//   bus  - slave side of mips_mem_responder_if (request in, rd_data/ready/err/busy out)
//
// Parameters: DEPTH_WORDS (array size), ADDR_W (word index width), READ_LAT (1..15).
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject addresses with address[1:0] != 0
// (err=1, no write, rd_data=0). Without it the low address bits are ignored.
module mips_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    mips_mem_responder_if.slave        bus
);

    localparam logic [3:0] LatInit = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              legal_q, legal_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] req_idx;
    logic              req_legal;
    logic              mem_we;
    logic              unused_addr_lsbs;

    assign req_idx          = bus.address[ADDR_W+1:2];
    assign unused_addr_lsbs = ^bus.address[1:0];

    always_comb begin
        req_legal = ((bus.address >> (ADDR_W + 2)) == 32'd0) &&
                    (32'(req_idx) < DEPTH_WORDS);
`ifdef MEM_ALIGN_CHECK_EN
        if (bus.address[1:0] != 2'b00) begin
            req_legal = 1'b0;
        end
`endif
    end

    // Gated by nrst so a write presented during reset never lands in the array.
    assign mem_we = nrst && (state_q == StIdle) && bus.MemWrite && !bus.MemRead && req_legal;

    // Array has no reset: contents survive nrst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        legal_d   = legal_q;
        rd_data_d = rd_data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.MemRead && bus.MemWrite) begin
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = StDone;
                end else if (bus.MemWrite) begin
                    ready_d = 1'b1;
                    err_d   = !req_legal;
                    // Illegal writes return a zero data word like every other error.
                    if (!req_legal) begin
                        rd_data_d = '0;
                    end
                    state_d = StDone;
                end else if (bus.MemRead) begin
                    idx_d   = req_idx;
                    legal_d = req_legal;
                    cnt_d   = LatInit;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_data_d = legal_q ? mem[idx_q] : '0;
                    err_d     = !legal_q;
                    ready_d   = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            legal_q   <= 1'b0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            legal_q   <= legal_d;
            rd_data_q <= rd_data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed bench for mips_mem_responder. Three instances with
// READ_LAT = 1, 3 and 4 share clock and reset; each request is checked for response
// latency, pulse count, busy duration, err and rd_data against hand-computed values.
module tb_mips_mem_responder;

    logic clk;
    logic nrst;

    logic        t_rd    [3];
    logic        t_wr    [3];
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic [31:0] o_rdata [3];
    logic        o_ready [3];
    logic        o_err   [3];
    logic        o_busy  [3];

    int n_checks;
    int n_errors;

    mips_mem_responder_if bus0 ();
    mips_mem_responder_if bus1 ();
    mips_mem_responder_if bus2 ();

    assign bus0.MemRead  = t_rd[0];
    assign bus0.MemWrite = t_wr[0];
    assign bus0.address  = t_addr[0];
    assign bus0.wr_data  = t_wdata[0];
    assign o_rdata[0]    = bus0.rd_data;
    assign o_ready[0]    = bus0.ready;
    assign o_err[0]      = bus0.err;
    assign o_busy[0]     = bus0.busy;

    assign bus1.MemRead  = t_rd[1];
    assign bus1.MemWrite = t_wr[1];
    assign bus1.address  = t_addr[1];
    assign bus1.wr_data  = t_wdata[1];
    assign o_rdata[1]    = bus1.rd_data;
    assign o_ready[1]    = bus1.ready;
    assign o_err[1]      = bus1.err;
    assign o_busy[1]     = bus1.busy;

    assign bus2.MemRead  = t_rd[2];
    assign bus2.MemWrite = t_wr[2];
    assign bus2.address  = t_addr[2];
    assign bus2.wr_data  = t_wdata[2];
    assign o_rdata[2]    = bus2.rd_data;
    assign o_ready[2]    = bus2.ready;
    assign o_err[2]      = bus2.err;
    assign o_busy[2]     = bus2.busy;

    mips_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .READ_LAT(1)) u_lat1 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus0)
    );

    mips_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .READ_LAT(3)) u_lat3 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus1)
    );

    mips_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .READ_LAT(4)) u_lat4 (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request, scrambles address/data right after acceptance, drops the
    // request once ready is seen and checks the response. exp_lat counts edges after
    // the acceptance edge (0 for writes/errors, READ_LAT for reads).
    task automatic do_req(input int inst, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic exp_err,
                          input logic chk_data, input logic [31:0] exp_data,
                          input string tag);
        int          first;
        int          pulses;
        int          busy_n;
        logic        got_err;
        logic [31:0] got_data;
        first    = -1;
        pulses   = 0;
        busy_n   = 0;
        got_err  = 1'b0;
        got_data = '0;
        @(negedge clk);
        t_rd[inst]    = rd;
        t_wr[inst]    = wr;
        t_addr[inst]  = a;
        t_wdata[inst] = d;
        @(posedge clk);
        #1;
        t_addr[inst]  = ~a;
        t_wdata[inst] = ~d;
        for (int n = 0; n < 16; n++) begin
            if (o_busy[inst]) busy_n++;
            if (o_ready[inst]) begin
                pulses++;
                if (first < 0) begin
                    first    = n;
                    got_err  = o_err[inst];
                    got_data = o_rdata[inst];
                end
                t_rd[inst] = 1'b0;
                t_wr[inst] = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        t_rd[inst] = 1'b0;
        t_wr[inst] = 1'b0;
        check_eq({tag, ".lat"}, 32'(first), 32'(exp_lat));
        check_eq({tag, ".pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, ".busy"}, 32'(busy_n), 32'(exp_lat + 1));
        check_eq({tag, ".err"}, 32'(got_err), 32'(exp_err));
        if (chk_data) check_eq({tag, ".data"}, got_data, exp_data);
    endtask

    initial begin
        int ready_seen;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 3; i++) begin
            t_rd[i]    = 1'b0;
            t_wr[i]    = 1'b0;
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst.ready", 32'(o_ready[i]), 32'd0);
            check_eq("rst.err", 32'(o_err[i]), 32'd0);
            check_eq("rst.busy", 32'(o_busy[i]), 32'd0);
            check_eq("rst.rd_data", o_rdata[i], 32'd0);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle.busy", 32'(o_busy[0]), 32'd0);

        // READ_LAT=1: basic write/read and rd_data hold across a write response.
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0, "wr10");
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd10");
        do_req(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "wr0");
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'hA5A5_A5A5, "rd0");

        // Both request lines high: error, no write.
        do_req(0, 1'b1, 1'b1, 32'h0, 32'h1111_1111, 0, 1'b1, 1'b1, 32'h0, "both");
        // Out-of-range 0x400 aliases word 0 in the index bits; it must not touch it.
        do_req(0, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, 0, 1'b1, 1'b1, 32'h0, "oor_wr");
        do_req(0, 1'b1, 1'b0, 32'h400, 32'h0, 1, 1'b1, 1'b1, 32'h0, "oor_rd");
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'hA5A5_A5A5, "rd0_after");
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd10_after");

        // Misaligned accesses.
`ifdef MEM_ALIGN_CHECK_EN
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b1, 1'b1, 32'h0, "mis_rd");
        do_req(0, 1'b0, 1'b1, 32'h12, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h0, "mis_wr");
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd10_mis");
`else
        do_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b0, 1'b1, 32'hDEAD_BEEF, "mis_rd");
        do_req(0, 1'b0, 1'b1, 32'h12, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 32'h0, "mis_wr");
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b1, 32'hCAFE_F00D, "rd10_mis");
`endif

        // READ_LAT=3.
        do_req(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, "l3_wr20");
        do_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0, 1'b1, 32'h1234_5678, "l3_rd20");
        do_req(1, 1'b0, 1'b1, 32'h3FC, 32'h0F0F_0F0F, 0, 1'b0, 1'b0, 32'h0, "l3_wrtop");
        do_req(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 3, 1'b0, 1'b1, 32'h0F0F_0F0F, "l3_rdtop");

        // READ_LAT=4: reset asserted while in RD_WAIT.
        do_req(2, 1'b0, 1'b1, 32'h8, 32'h0BAD_CAFE, 0, 1'b0, 1'b0, 32'h0, "l4_wr8");
        do_req(2, 1'b1, 1'b0, 32'h8, 32'h0, 4, 1'b0, 1'b1, 32'h0BAD_CAFE, "l4_rd8");
        @(negedge clk);
        t_rd[2]   = 1'b1;
        t_addr[2] = 32'h8;
        @(posedge clk);
        #1;
        check_eq("abort.accepted", 32'(o_busy[2]), 32'd1);
        @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check_eq("abort.busy", 32'(o_busy[2]), 32'd0);
        check_eq("abort.ready", 32'(o_ready[2]), 32'd0);
        check_eq("abort.rd_data", o_rdata[2], 32'd0);
        t_rd[2] = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        ready_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (o_ready[2]) ready_seen++;
        end
        check_eq("abort.no_ready", 32'(ready_seen), 32'd0);
        do_req(2, 1'b1, 1'b0, 32'h8, 32'h0, 4, 1'b0, 1'b1, 32'h0BAD_CAFE, "l4_kept");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Word-wide unified instruction/data memory that answers the multi-cycle MIPS32 core's memory port (MemRead, MemWrite, address, write data).
- Accepts one request at a time from IDLE and runs a small FSM for a configurable read latency.
- Returns registered read data with a one-cycle ready pulse and flags illegal accesses.
- Sits between the core and the top-level testbench/SoC wrapper.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array.
- ADDR_W, 8, log2(DEPTH_WORDS); word index width.
- READ_LAT, 1, number of clock edges from read acceptance to data load; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  reset, asynchronous, active-low.
- MemRead  input  1  read request level from core.
- MemWrite  input  1  write request level from core.
- address  input  32  byte address from core.
- wr_data  input  32  write data; the core's data_out.
- rd_data  output  32  read data; the core's data_in.
- ready  output  1  one-cycle response pulse.
- err  output  1  response error flag; valid only while ready=1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (nrst=0, async): state=IDLE, rd_data=0, ready=0, err=0, busy=0, latency counter=0. Array contents are not cleared. Reset mid-transaction aborts it; a pending write already committed stays committed.
- Word index idx = address[ADDR_W+1:2]. Out-of-range when address[31:ADDR_W+2] != 0.
- States: IDLE, RD_WAIT, DONE. busy = (state != IDLE).
- IDLE, acceptance edge k:
  - MemWrite=1, MemRead=0, legal: mem[idx] <= wr_data at edge k; ready<=1, err<=0; go to DONE.
  - MemRead=1, MemWrite=0: latch idx and legality; cnt <= READ_LAT-1; go to RD_WAIT.
  - Both MemRead and MemWrite high: no array access; ready<=1, err<=1, rd_data<=0; go to DONE.
  - Illegal write: no array access; ready<=1, err<=1; go to DONE.
  - Neither high: stay in IDLE; ready<=0.
- RD_WAIT:
  - cnt != 0: cnt decrements.
  - cnt == 0: rd_data <= mem[idx] (or 0 with err<=1 if illegal); ready<=1; go to DONE.
  - Read response is visible between edges k+READ_LAT and k+READ_LAT+1.
- DONE: ready<=0, err<=0; go to IDLE. rd_data holds until the next read response.
- Requests presented in RD_WAIT or DONE are ignored and not queued. The requester must hold the request until ready and then drop it or re-present it. Earliest next acceptance is 2 edges after the previous response edge.
- Read-after-write to the same word returns the new data; the write commits at its acceptance edge.
- address and wr_data are sampled only at the acceptance edge. Later changes have no effect on the accepted transaction.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: address[1:0] != 0 is illegal. Response is err=1, no write, rd_data=0, with normal timing.
- Undefined: address[1:0] is ignored and the access is silently word-aligned.

Test Plan:
- Reset release, then write 0xDEADBEEF at address 0x10 with READ_LAT=1. Expected: ready=1, err=0 in the cycle after acceptance. A following read of 0x10 gives rd_data=0xDEADBEEF with ready one edge after read acceptance.
- READ_LAT=3: read address 0x20 after writing 0x12345678 there. Expected: busy=1 for 4 cycles, ready pulses exactly once at edge k+3, rd_data=0x12345678.
- MemRead=MemWrite=1 at 0x0 while mem[0]=0xA5A5A5A5. Expected: ready=1, err=1, rd_data=0, and mem[0] still reads 0xA5A5A5A5.
- Address 0x00000400 with DEPTH_WORDS=256 (out of range): write then read. Expected: both responses have err=1, rd_data=0, and no word of the array is modified.
- Misaligned address 0x13, reading back a word written at 0x10. With MEM_ALIGN_CHECK_EN: err=1, rd_data=0. Without it: err=0 and data equals the word at 0x10.
- Deassert nrst while in RD_WAIT (READ_LAT=4). Expected: immediate async return to IDLE with ready=0, busy=0, rd_data=0, and no ready pulse after nrst is released.
